// File: rtl/halt_drain_pkg.sv
// Shared types and helpers for the end-of-program halt/drain controller.
package halt_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    READ,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  localparam logic [15:0] HALT_A = 16'hE000;
  localparam logic [15:0] HALT_B = 16'hE7FF;

  // Only the two canonical halt encodings count; other 11100 opcodes are ordinary instructions.
  function automatic logic is_halt(input logic [15:0] instr, input logic valid);
    return valid && ((instr == HALT_A) || (instr == HALT_B));
  endfunction

endpackage

// File: rtl/halt_drain_unit_sat_counter.sv
// Up-counter that sticks at all ones instead of wrapping; clear wins over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/halt_drain_unit.sv
// Watches the issued stream for a halt, drains the pipeline, freezes the core,
// then fetches the result word from data memory and hands it out on valid/ready.
module halt_drain_unit
  import halt_drain_pkg::*;
#(
  parameter int INSTR_W      = 16,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int DRAIN_CYCLES = 10,
  parameter int RESULT_ADDR  = 1,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               cpu_halt,
  output logic [DATA_W-1:0]  result_data,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                cnt_clr, cnt_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      result_q <= result_d;
    end
  end

  // Drain counter starts at DRAIN_CYCLES-1 so DRAIN occupies exactly DRAIN_CYCLES cycles.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    result_d = result_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (is_halt(instr, instr_valid)) begin
          drain_d = DRAIN_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = READ;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      READ:    state_d = WAIT;
      WAIT: begin
        result_d = mem_rd_data;
        state_d  = PRESENT;
      end
      PRESENT: begin
        if (result_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (clear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cycle_count)
  );

  assign mem_rd_en    = (state_q == READ);
  assign mem_addr     = (state_q == READ) ? ADDR_W'(RESULT_ADDR) : '0;
  assign cpu_halt     = (state_q == READ) || (state_q == WAIT) ||
                        (state_q == PRESENT) || (state_q == DONE);
  assign result_valid = (state_q == PRESENT);
  assign done         = (state_q == DONE);
  assign result_data  = result_q;

endmodule

// File: tb/tb_halt_drain_unit.sv
// Directed bench for halt_drain_unit: cycle table for a basic run plus hand-written corner sequences.
module tb_halt_drain_unit;

  logic        clk = 1'b0;
  logic        reset, start, clear, instrValid, resultReady;
  logic [15:0] instr;
  logic        memRdEn, cpuHalt, resultValid, done;
  logic [9:0]  memAddr;
  logic [15:0] resultData;
  logic [31:0] cycleCount;
  logic        memRdEnS, cpuHaltS, resultValidS, doneS;
  logic [9:0]  memAddrS;
  logic [15:0] resultDataS;
  logic [3:0]  cycleCountS;
  logic [15:0] memRdData = 16'h0000;
  logic [15:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        start;
    logic        clear;
    logic [15:0] instr;
    logic        instrValid;
    logic        resultReady;
    logic        expRdEn;
    logic [9:0]  expAddr;
    logic        expHalt;
    logic        expValid;
    logic        expDone;
    logic [15:0] expData;
    logic [31:0] expCount;
  } vec_t;

  vec_t vecs [0:20];

  always #5 clk = ~clk;

  // Synchronous-read data memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (memRdEn) memRdData <= mem[memAddr];
  end

  halt_drain_unit dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .instr(instr), .instr_valid(instrValid),
    .mem_rd_en(memRdEn), .mem_addr(memAddr), .mem_rd_data(memRdData),
    .cpu_halt(cpuHalt), .result_data(resultData), .result_valid(resultValid),
    .result_ready(resultReady), .done(done), .cycle_count(cycleCount)
  );

  halt_drain_unit #(.CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .instr(instr), .instr_valid(instrValid),
    .mem_rd_en(memRdEnS), .mem_addr(memAddrS), .mem_rd_data(memRdData),
    .cpu_halt(cpuHaltS), .result_data(resultDataS), .result_valid(resultValidS),
    .result_ready(resultReady), .done(doneS), .cycle_count(cycleCountS)
  );

  function automatic vec_t mkVec(logic s, logic c, logic [15:0] ins, logic v, logic r,
                                 logic rdEn, logic [9:0] addr, logic hlt, logic vld,
                                 logic dn, logic [15:0] data, logic [31:0] cnt);
    vec_t x;
    x.start = s; x.clear = c; x.instr = ins; x.instrValid = v; x.resultReady = r;
    x.expRdEn = rdEn; x.expAddr = addr; x.expHalt = hlt; x.expValid = vld;
    x.expDone = dn; x.expData = data; x.expCount = cnt;
    return x;
  endfunction

  task automatic applyStimulus(input logic s, input logic c, input logic [15:0] ins,
                               input logic v, input logic r);
    start = s; clear = c; instr = ins; instrValid = v; resultReady = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Steps idle cycles until the read strobe shows up; n=51 means it never did.
  task automatic waitRdEn(input logic r, output int n);
    n = 51;
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, r);
      if (memRdEn) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    for (int a = 0; a < 1024; a++) mem[a] = 16'hDEAD;
    mem[0] = 16'h1111;
    mem[1] = 16'h00A5;
    mem[2] = 16'h2222;
    reset = 1'b1; start = 1'b0; clear = 1'b0; instr = '0; instrValid = 1'b0; resultReady = 1'b0;

    // Basic run, one row per clock: inputs for the cycle, then outputs seen after its edge.
    vecs[0]  = mkVec(1, 0, 16'h0000, 0, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 0);
    vecs[1]  = mkVec(0, 0, 16'h1111, 1, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 1);
    vecs[2]  = mkVec(0, 0, 16'h2222, 1, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 2);
    vecs[3]  = mkVec(0, 0, 16'h3333, 1, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 3);
    vecs[4]  = mkVec(0, 0, 16'h4444, 1, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 4);
    vecs[5]  = mkVec(0, 0, 16'h5555, 1, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 5);
    vecs[6]  = mkVec(0, 0, 16'hE000, 1, 1,  0, 10'd0, 0, 0, 0, 16'h0000, 6);
    for (int i = 7; i <= 15; i++)
      vecs[i] = mkVec(0, 0, 16'h0000, 0, 1, 0, 10'd0, 0, 0, 0, 16'h0000, 6);
    vecs[16] = mkVec(0, 0, 16'h0000, 0, 1,  1, 10'd1, 1, 0, 0, 16'h0000, 6);
    vecs[17] = mkVec(0, 0, 16'h0000, 0, 1,  0, 10'd0, 1, 0, 0, 16'h0000, 6);
    vecs[18] = mkVec(0, 0, 16'h0000, 0, 1,  0, 10'd0, 1, 1, 0, 16'h00A5, 6);
    vecs[19] = mkVec(0, 0, 16'h0000, 0, 1,  0, 10'd0, 1, 0, 1, 16'h00A5, 6);
    vecs[20] = mkVec(0, 1, 16'h0000, 0, 1,  0, 10'd0, 0, 0, 0, 16'h00A5, 6);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset rd_en", 32'(memRdEn), 0);
    checkOutput("reset addr", 32'(memAddr), 0);
    checkOutput("reset cpu_halt", 32'(cpuHalt), 0);
    checkOutput("reset result_data", 32'(resultData), 0);
    checkOutput("reset result_valid", 32'(resultValid), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset cycle_count", cycleCount, 0);
    reset = 1'b0;

    for (int i = 0; i <= 20; i++) begin
      applyStimulus(vecs[i].start, vecs[i].clear, vecs[i].instr, vecs[i].instrValid, vecs[i].resultReady);
      checkOutput($sformatf("row%0d rd_en", i), 32'(memRdEn), 32'(vecs[i].expRdEn));
      checkOutput($sformatf("row%0d addr", i), 32'(memAddr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("row%0d cpu_halt", i), 32'(cpuHalt), 32'(vecs[i].expHalt));
      checkOutput($sformatf("row%0d valid", i), 32'(resultValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].expDone));
      checkOutput($sformatf("row%0d data", i), 32'(resultData), 32'(vecs[i].expData));
      checkOutput($sformatf("row%0d count", i), cycleCount, vecs[i].expCount);
    end

    // Lookalikes, ignored controls in DRAIN/PRESENT, and backpressure.
    mem[1] = 16'h5A3C;
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("look start count", cycleCount, 0);
    applyStimulus(0, 0, 16'hE001, 1, 0);
    checkOutput("look E001 count", cycleCount, 1);
    applyStimulus(0, 0, 16'hE7FF, 0, 0);
    checkOutput("look invalid E7FF count", cycleCount, 2);
    applyStimulus(0, 0, 16'hE7FF, 1, 0);
    checkOutput("look E7FF count", cycleCount, 3);
    n = 51;
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(k == 2, k == 5, (k == 4) ? 16'hE000 : 16'h0000, k == 4, 0);
      if (memRdEn) begin
        n = k;
        break;
      end
    end
    checkOutput("drain len with start+halt", 32'(n), 10);
    checkOutput("drain addr", 32'(memAddr), 1);
    checkOutput("drain count frozen", cycleCount, 3);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkOutput("bp first valid", 32'(resultValid), 1);
    checkOutput("bp first data", 32'(resultData), 32'h5A3C);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, k == 3, 16'h0000, 0, 0);
      checkOutput($sformatf("bp%0d valid", k), 32'(resultValid), 1);
      checkOutput($sformatf("bp%0d data", k), 32'(resultData), 32'h5A3C);
      checkOutput($sformatf("bp%0d done", k), 32'(done), 0);
    end
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("bp accept done", 32'(done), 1);
    checkOutput("bp accept valid", 32'(resultValid), 0);
    checkOutput("bp accept cpu_halt", 32'(cpuHalt), 1);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("done holds", 32'(done), 1);
    applyStimulus(0, 1, 16'h0000, 0, 0);
    checkOutput("clear cpu_halt", 32'(cpuHalt), 0);
    checkOutput("clear done", 32'(done), 0);
    checkOutput("clear data kept", 32'(resultData), 32'h5A3C);

    // Async reset between edges: mid-DRAIN, then mid-PRESENT.
    mem[1] = 16'h0F0F;
    applyStimulus(1, 0, 16'h0000, 0, 0);
    applyStimulus(0, 0, 16'h1234, 1, 0);
    applyStimulus(0, 0, 16'h2345, 1, 0);
    applyStimulus(0, 0, 16'hE000, 1, 0);
    checkOutput("pre-reset count", cycleCount, 3);
    repeat (3) applyStimulus(0, 0, 16'h0000, 0, 0);
    #3 reset = 1'b1;
    #1;
    checkOutput("async drain count", cycleCount, 0);
    checkOutput("async drain cpu_halt", 32'(cpuHalt), 0);
    checkOutput("async drain valid", 32'(resultValid), 0);
    checkOutput("async drain done", 32'(done), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1, 0, 16'h0000, 0, 0);
    applyStimulus(0, 0, 16'h1234, 1, 0);
    applyStimulus(0, 0, 16'hE000, 1, 0);
    checkOutput("post-reset count", cycleCount, 2);
    waitRdEn(1'b0, n);
    checkOutput("post-reset drain len", 32'(n), 10);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkOutput("post-reset valid", 32'(resultValid), 1);
    checkOutput("post-reset data", 32'(resultData), 32'h0F0F);
    #3 reset = 1'b1;
    #1;
    checkOutput("async present valid", 32'(resultValid), 0);
    checkOutput("async present cpu_halt", 32'(cpuHalt), 0);
    checkOutput("async present data", 32'(resultData), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Saturation: narrow counter sticks at 15 while the wide one keeps going.
    mem[1] = 16'h7E81;
    applyStimulus(1, 0, 16'h0000, 0, 1);
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 16'h0100 + 16'(k), 1, 1);
    applyStimulus(0, 0, 16'hE7FF, 1, 1);
    checkOutput("sat narrow count", 32'(cycleCountS), 15);
    checkOutput("sat wide count", cycleCount, 21);
    waitRdEn(1'b1, n);
    checkOutput("sat drain len", 32'(n), 10);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("sat done", 32'(doneS), 1);
    checkOutput("sat data", 32'(resultDataS), 32'h7E81);
    checkOutput("sat count held", 32'(cycleCountS), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
